// File: rtl/claa_chain_seq.sv
// Multi-cycle wide adder: steps one WORD_WIDTH-bit carry-lookahead slice across WORDS
// slices, LSB first, with the slice carry-out registered between cycles.

module claa_slice #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             c_i,
  output logic [WIDTH-1:0] r_o,
  output logic             c_o
);
  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH:0]   c;
  logic             prop;
  logic             acc;

  always_comb begin
    g    = a_i & b_i;
    p    = a_i ^ b_i;
    c    = '0;
    prop = 1'b0;
    acc  = 1'b0;
    c[0] = c_i;
    // Each carry is the flat sum-of-products g[i] | p[i]g[i-1] | ... | p[i..0]c_i.
    for (int unsigned i = 0; i < WIDTH; i++) begin
      prop = 1'b1;
      acc  = 1'b0;
      for (int unsigned j = 0; j <= i; j++) begin
        acc  = acc | (prop & g[i-j]);
        prop = prop & p[i-j];
      end
      c[i+1] = acc | (prop & c_i);
    end
    r_o = p ^ c[WIDTH-1:0];
    c_o = c[WIDTH];
  end
endmodule

module claa_chain_seq #(
  parameter int unsigned WORD_WIDTH = 8,
  parameter int unsigned WORDS      = 4,
  localparam int unsigned W         = WORD_WIDTH * WORDS,
  localparam int unsigned IDXW      = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic         c_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic         valid_o,
  input  logic         ready_i,
  output logic [W-1:0] r_o,
  output logic         c_o,
  output logic         v_o,
  output logic         z_o
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state_q, state_d;
  logic [W-1:0]          a_q, a_d, b_q, b_d, r_q, r_d;
  logic                  carry_q, carry_d;
  logic                  c_q, c_d, v_q, v_d, z_q, z_d;
  logic [IDXW-1:0]       idx_q, idx_d;
  logic [WORD_WIDTH-1:0] slice_a, slice_b, slice_r;
  logic                  slice_c;
  logic                  last;

  claa_slice #(.WIDTH(WORD_WIDTH)) u_slice (
    .a_i (slice_a),
    .b_i (slice_b),
    .c_i (carry_q),
    .r_o (slice_r),
    .c_o (slice_c)
  );

  always_comb begin
    slice_a = a_q[idx_q*WORD_WIDTH +: WORD_WIDTH];
    slice_b = b_q[idx_q*WORD_WIDTH +: WORD_WIDTH];
    last    = (idx_q == IDXW'(WORDS - 1));
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    c_d     = c_q;
    v_d     = v_q;
    z_d     = z_q;
    unique case (state_q)
      IDLE: begin
        if (valid_i) begin
          a_d     = a_i;
          b_d     = b_i;
          carry_d = c_i;
          idx_d   = '0;
          r_d     = '0;
          c_d     = 1'b0;
          v_d     = 1'b0;
          z_d     = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        r_d[idx_q*WORD_WIDTH +: WORD_WIDTH] = slice_r;
        carry_d = slice_c;
        idx_d   = idx_q + IDXW'(1);
        if (last) begin
          // MSB carry-in recovered from a^b^r at the top bit of the final slice.
          c_d     = slice_c;
          v_d     = (slice_a[WORD_WIDTH-1] ^ slice_b[WORD_WIDTH-1] ^ slice_r[WORD_WIDTH-1])
                    ^ slice_c;
          z_d     = ~|r_d;
          state_d = DONE;
        end
      end
      DONE: begin
        if (ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      c_q     <= c_d;
      v_q     <= v_d;
      z_q     <= z_d;
    end
  end

  always_comb begin
    ready_o = (state_q == IDLE);
    valid_o = (state_q == DONE);
    r_o     = r_q;
    c_o     = c_q;
    v_o     = v_q;
    z_o     = z_q;
  end
endmodule

// File: tb/tb_claa_chain_seq.sv
// Randomized bench for claa_chain_seq, compared against a plain (W+1)-bit addition model.

module tb_claa_chain_seq;
  localparam int unsigned WORD_WIDTH = 8;
  localparam int unsigned WORDS      = 4;
  localparam int unsigned W          = WORD_WIDTH * WORDS;
  localparam int unsigned N_RANDOM   = 4000;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic         valid_i = 1'b0;
  logic         ready_o;
  logic         c_i = 1'b0;
  logic [W-1:0] a_i = '0;
  logic [W-1:0] b_i = '0;
  logic         valid_o;
  logic         ready_i = 1'b0;
  logic [W-1:0] r_o;
  logic         c_o;
  logic         v_o;
  logic         z_o;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  claa_chain_seq #(.WORD_WIDTH(WORD_WIDTH), .WORDS(WORDS)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .c_i     (c_i),
    .a_i     (a_i),
    .b_i     (b_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .r_o     (r_o),
    .c_o     (c_o),
    .v_o     (v_o),
    .z_o     (z_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Issues one operation from IDLE and retires it; hold = DONE cycles with ready_i low.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input int unsigned hold);
    logic [W:0]   sum;
    logic [W-1:0] er;
    logic         ec, ev, ez;
    int unsigned  lat;
    sum = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    er  = sum[W-1:0];
    ec  = sum[W];
    ev  = (a[W-1] == b[W-1]) && (er[W-1] != a[W-1]);
    ez  = (er == '0);

    check("ready_idle", 64'(ready_o), 64'(1));
    a_i = a; b_i = b; c_i = cin; valid_i = 1'b1;
    tick();
    a_i = W'($urandom); b_i = W'($urandom); c_i = 1'($urandom);
    lat = 0;
    while (!valid_o && lat < 20) begin
      valid_i = 1'($urandom);
      ready_i = 1'($urandom);
      tick();
      lat++;
      a_i = W'($urandom); b_i = W'($urandom);
    end
    check("latency", 64'(lat), 64'(WORDS));
    for (int unsigned k = 0; k < hold; k++) begin
      ready_i = 1'b0;
      valid_i = 1'b1;
      tick();
      check("hold_valid", 64'(valid_o), 64'(1));
      check("hold_ready", 64'(ready_o), 64'(0));
      check("hold_r", 64'(r_o), 64'(er));
    end
    check("ready_busy", 64'(ready_o), 64'(0));
    check("r", 64'(r_o), 64'(er));
    check("c", 64'(c_o), 64'(ec));
    check("v", 64'(v_o), 64'(ev));
    check("z", 64'(z_o), 64'(ez));
    valid_i = 1'b0;
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
    check("retire_valid", 64'(valid_o), 64'(0));
    check("retire_ready", 64'(ready_o), 64'(1));
  endtask

  initial begin
    #2;
    check("rst_valid", 64'(valid_o), 64'(0));
    check("rst_ready", 64'(ready_o), 64'(1));
    check("rst_r", 64'(r_o), 64'(0));
    check("rst_flags", 64'({c_o, v_o, z_o}), 64'(0));
    #10 rst_i = 1'b0;
    tick();

    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0);
    run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 0);
    run_op(32'h1234_5678, 32'h0000_FFFF, 1'b1, 0);
    run_op(32'h8000_0000, 32'h8000_0000, 1'b0, 0);
    run_op(32'h0000_0000, 32'h0000_0000, 1'b0, 0);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 5);

    // Asynchronous reset after two slices have been processed.
    a_i = 32'hFFFF_FFFF; b_i = 32'hFFFF_FFFF; c_i = 1'b1; valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    tick();
    tick();
    #2 rst_i = 1'b1;
    #1;
    check("arst_valid", 64'(valid_o), 64'(0));
    check("arst_r", 64'(r_o), 64'(0));
    check("arst_flags", 64'({c_o, v_o, z_o}), 64'(0));
    #3 rst_i = 1'b0;
    tick();
    check("arst_ready", 64'(ready_o), 64'(1));
    run_op(32'h0F0F_0F0F, 32'hF0F0_F0F1, 1'b0, 1);

    for (int unsigned n = 0; n < N_RANDOM; n++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom);
      rb = W'($urandom);
      case ($urandom_range(0, 7))
        0: rb = ~ra;
        1: ra = W'(0);
        2: rb = W'({1'b0, {(W-1){1'b1}}});
        default: ;
      endcase
      run_op(ra, rb, 1'($urandom), $urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
